led_cmd_uart_rx: RTL and testbench
==================================

Name: led_cmd_uart_rx

Overview:
- UART command receiver and parser that sits directly upstream of the 8-channel PWM LED stage.
- Receives 8N1 serial bytes on a single RX pin and decodes 3-byte frames (header, channel index, brightness).
- Emits a single-cycle write strobe carrying channel index and 8-bit brightness. The PWM stage latches the pair into its per-LED brightness register.
- Malformed frames are dropped and flagged. A frame that goes silent between bytes is abandoned.

Parameters:
- CLK_FREQ, 25_000_000, system clock frequency in Hz.
- BAUD, 115_200, serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be >= 8).
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_BITS, 40, maximum idle gap between bytes of one frame, in bit periods.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input; idle high; asynchronous to clk.
- wr_en  out  1  one-cycle pulse: a valid brightness write is present.
- wr_index  out  3  channel 0..7; valid while wr_en=1, held otherwise.
- wr_value  out  8  brightness 0..255; valid while wr_en=1, held otherwise.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- cmd_err  out  1  one-cycle pulse: index byte > 7 or parser timeout.
- busy  out  1  high from frame header acceptance until frame completion or abort.

Behaviour:
- Reset (async, rst_n=0) values:
  - wr_en, frame_err, cmd_err, busy = 0; wr_index = 0; wr_value = 0.
  - Synchronizer flops = 1; RX FSM = IDLE; parser = WAIT_HDR; all counters = 0.
- Reset mid-byte or mid-frame discards all partial data. No strobe is issued.
- rx passes through a 2-flop synchronizer. All references to rx below mean the synchronized signal.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx=0 -> START, bit counter cleared.
  - START: wait CLKS_PER_BIT/2 clocks, then sample. If rx=1, treat as a glitch and return to IDLE with no error. If rx=0, go to DATA.
  - DATA: every CLKS_PER_BIT clocks, sample one bit, LSB first. After bit 7 -> STOP.
  - STOP: after CLKS_PER_BIT clocks, sample.
    - rx=1: internal byte_valid pulses 1 cycle with byte_data, then -> IDLE.
    - rx=0: frame_err pulses 1 cycle, no byte_valid, parser forced to WAIT_HDR, busy drops. FSM then waits in IDLE-pending until rx=1 before re-arming, so a break condition does not retrigger.
- Parser FSM states: WAIT_HDR, WAIT_IDX, WAIT_VAL.
  - WAIT_HDR: byte == HEADER -> WAIT_IDX, busy=1. Any other byte is ignored silently.
  - WAIT_IDX: byte <= 7 -> store index, go to WAIT_VAL. Byte > 7 -> cmd_err pulse, go to WAIT_HDR, busy=0.
  - WAIT_VAL: any byte (0..255) -> wr_en=1 on the next clock with wr_index/wr_value updated in the same cycle, go to WAIT_HDR, busy=0.
  - A HEADER value arriving in WAIT_IDX is treated as index (>7, so cmd_err). It does not resync.
- Timeout:
  - In WAIT_IDX or WAIT_VAL, a gap counter counts clocks while the RX FSM is in IDLE. It resets on every byte_valid.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT -> cmd_err pulse, parser to WAIT_HDR, busy=0.
  - Counter is inactive in WAIT_HDR.
- Latency: wr_en asserts exactly 1 clock after the byte_valid of the value byte. Measured from the value byte's start-bit falling edge on rx, wr_en asserts at 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 or 2 clocks.
- Simultaneous events:
  - Timeout and byte_valid in the same cycle: byte_valid wins, counter resets.
  - frame_err and timeout in the same cycle: only frame_err pulses.
- Back-to-back frames with no idle gap beyond the stop bit must all be accepted. wr_en pulses are never merged.
- Error pulses never coincide with wr_en.

Test Plan (CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clk/bit):
- Send A5 03 80 -> exactly one wr_en pulse with wr_index=3, wr_value=0x80. busy high from the header stop bit to wr_en. No error pulses.
- Send A5 07 FF then immediately A5 00 00 -> two wr_en pulses: (7, 0xFF) then (0, 0x00). Outputs hold (0, 0x00) afterwards.
- Send 12 A5 09 55 -> no wr_en. cmd_err pulses once after the 0x09 byte. 0x55 is ignored in WAIT_HDR.
- Send A5, then idle 400 clocks, then 02 10 -> cmd_err at clock 400 of the gap, no wr_en. Then A5 02 10 -> wr_en (2, 0x10).
- Send A5 with stop bit forced low -> frame_err pulse, busy=0. Then a 3-clock rx low glitch -> no byte decoded, no error.
- Assert rst_n=0 during the value byte of A5 04 77 -> no wr_en. All outputs return to reset values. Next clean frame A5 04 77 -> wr_en (4, 0x77).

Source files
------------

// File: rtl/led_cmd_uart_rx.sv
// led_cmd_uart_rx: 8N1 UART receiver that decodes HEADER/index/value frames into LED brightness writes
module led_cmd_uart_rx #(
    parameter int         CLK_FREQ     = 25_000_000,
    parameter int         BAUD         = 115_200,
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         TIMEOUT_BITS = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       wr_en,
    output logic [2:0] wr_index,
    output logic [7:0] wr_value,
    output logic       frame_err,
    output logic       cmd_err,
    output logic       busy
);
    localparam int CPB     = CLK_FREQ / BAUD;
    localparam int CW      = $clog2(CPB);
    localparam int TO_CLKS = TIMEOUT_BITS * CPB;
    localparam int GW      = $clog2(TO_CLKS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CPB - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(TO_CLKS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_t;
    typedef enum logic [1:0] {WAIT_HDR, WAIT_IDX, WAIT_VAL} p_state_t;

    logic [1:0]    sync_q;
    logic          rxs;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] clk_cnt, clk_cnt_d;
    logic [2:0]    bit_cnt, bit_cnt_d;
    logic [7:0]    shreg, shreg_d;
    logic          byte_valid, stop_err, bv_q;
    p_state_t      p_state, p_next;
    logic [GW-1:0] gap, gap_d;
    logic [2:0]    idx, idx_d, wr_index_d;
    logic [7:0]    wr_value_d;
    logic          wr_en_d, cmd_err_d, timeout;

    assign rxs  = sync_q[1];
    assign busy = p_state != WAIT_HDR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_state  <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            bv_q      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_state  <= rx_next;
            clk_cnt   <= clk_cnt_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            bv_q      <= byte_valid;
            frame_err <= stop_err;
        end
    end

    always_comb begin
        rx_next    = rx_state;
        clk_cnt_d  = clk_cnt + 1'b1;
        bit_cnt_d  = bit_cnt;
        shreg_d    = shreg;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (rx_state)
            IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                rx_next   = rxs ? IDLE : START;
            end
            START: if (clk_cnt == HALF_LAST) begin
                clk_cnt_d = '0;
                rx_next   = rxs ? IDLE : DATA;
            end
            DATA: if (clk_cnt == FULL_LAST) begin
                clk_cnt_d = '0;
                shreg_d   = {rxs, shreg[7:1]};
                bit_cnt_d = bit_cnt + 1'b1;
                rx_next   = (bit_cnt == 3'd7) ? STOP : DATA;
            end
            STOP: if (clk_cnt == FULL_LAST) begin
                clk_cnt_d  = '0;
                byte_valid = rxs;
                stop_err   = !rxs;
                rx_next    = rxs ? IDLE : BRK;
            end
            BRK: begin
                // a held-low line must return high before another start bit is accepted
                clk_cnt_d = '0;
                rx_next   = rxs ? IDLE : BRK;
            end
            default: rx_next = IDLE;
        endcase
    end

    assign timeout = busy && rx_state == IDLE && gap == GAP_LAST;

    always_comb begin
        p_next     = p_state;
        idx_d      = idx;
        wr_en_d    = 1'b0;
        cmd_err_d  = 1'b0;
        wr_index_d = wr_index;
        wr_value_d = wr_value;
        if (stop_err) p_next = WAIT_HDR;
        else if (bv_q) begin
            case (p_state)
                WAIT_HDR: p_next = (shreg == HEADER) ? WAIT_IDX : WAIT_HDR;
                WAIT_IDX: begin
                    idx_d     = shreg[2:0];
                    cmd_err_d = shreg > 8'd7;
                    p_next    = (shreg > 8'd7) ? WAIT_HDR : WAIT_VAL;
                end
                WAIT_VAL: begin
                    wr_en_d    = 1'b1;
                    wr_index_d = idx;
                    wr_value_d = shreg;
                    p_next     = WAIT_HDR;
                end
                default: p_next = WAIT_HDR;
            endcase
        end else if (timeout) begin
            cmd_err_d = 1'b1;
            p_next    = WAIT_HDR;
        end
        gap_d = (p_next == WAIT_HDR || bv_q) ? '0 : gap + GW'(rx_state == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state  <= WAIT_HDR;
            gap      <= '0;
            idx      <= '0;
            wr_en    <= 1'b0;
            wr_index <= '0;
            wr_value <= '0;
            cmd_err  <= 1'b0;
        end else begin
            p_state  <= p_next;
            gap      <= gap_d;
            idx      <= idx_d;
            wr_en    <= wr_en_d;
            wr_index <= wr_index_d;
            wr_value <= wr_value_d;
            cmd_err  <= cmd_err_d;
        end
    end
endmodule

// File: tb/tb_led_cmd_uart_rx.sv
// tb_led_cmd_uart_rx: randomized frame streams checked against a byte-level frame scanner model
module tb_led_cmd_uart_rx;
    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       wr_en, frame_err, cmd_err, busy;
    logic [2:0] wr_index;
    logic [7:0] wr_value;

    int         checks = 0;
    int         errors = 0;
    int         n_cmd = 0;
    int         n_fe = 0;
    int         exp_cmd;
    logic [2:0] got_idx[$];
    logic [7:0] got_val[$];
    logic [2:0] exp_idx[$];
    logic [7:0] exp_val[$];
    logic [7:0] stim[$];
    time        wr_time, last_start;

    led_cmd_uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .HEADER(8'hA5), .TIMEOUT_BITS(40)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .wr_en(wr_en), .wr_index(wr_index),
        .wr_value(wr_value), .frame_err(frame_err), .cmd_err(cmd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            got_idx.push_back(wr_index);
            got_val.push_back(wr_value);
            wr_time = $time;
            checks++;
            if (cmd_err || frame_err) begin
                errors++;
                $display("FAIL err_with_wr: cmd_err=%0b frame_err=%0b required 0 0", cmd_err, frame_err);
            end
        end
        if (cmd_err) n_cmd++;
        if (frame_err) n_fe++;
    end

    initial begin
        repeat (200000) @(negedge clk);
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_mon();
        got_idx.delete();
        got_val.delete();
        n_cmd = 0;
        n_fe = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        last_start = $time;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_stim();
        foreach (stim[i]) send_byte(stim[i]);
    endtask

    // scans the byte stream for HEADER-led frames; an unfinished frame ends in a timeout
    task automatic model_stim();
        int i = 0;
        exp_idx.delete();
        exp_val.delete();
        exp_cmd = 0;
        while (i < stim.size()) begin
            if (stim[i] != 8'hA5) i++;
            else if (i + 1 >= stim.size()) begin exp_cmd++; i++; end
            else if (stim[i+1] > 8'd7) begin exp_cmd++; i += 2; end
            else if (i + 2 >= stim.size()) begin exp_cmd++; i += 3; end
            else begin
                exp_idx.push_back(stim[i+1][2:0]);
                exp_val.push_back(stim[i+2]);
                i += 3;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        checks++;
        if (got_idx.size() != exp_idx.size()) begin
            errors++;
            $display("FAIL %s wr_count: got %0d required %0d", tag, got_idx.size(), exp_idx.size());
        end
        foreach (exp_idx[i]) begin
            checks++;
            if (got_idx[i] !== exp_idx[i] || got_val[i] !== exp_val[i]) begin
                errors++;
                $display("FAIL %s wr[%0d]: got (%0d,%h) required (%0d,%h)", tag, i, got_idx[i], got_val[i], exp_idx[i], exp_val[i]);
            end
        end
        checks++;
        if (n_cmd != exp_cmd || n_fe != 0) begin
            errors++;
            $display("FAIL %s errs: cmd_err=%0d frame_err=%0d required %0d 0", tag, n_cmd, n_fe, exp_cmd);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({wr_en, wr_index, wr_value, frame_err, cmd_err, busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero", {wr_en, wr_index, wr_value, frame_err, cmd_err, busy});
        end
    endtask

    task automatic test_single();
        clear_mon();
        send_byte(8'hA5);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hdr: got %b required 1", busy); end
        send_byte(8'h03);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_idx: got %b required 1", busy); end
        send_byte(8'h80);
        repeat (5) @(negedge clk);
        checks++;
        if (got_idx.size() != 1 || got_idx[0] !== 3'd3 || got_val[0] !== 8'h80) begin
            errors++;
            $display("FAIL single_wr: got %0d writes first (%0d,%h) required 1 (3,80)", got_idx.size(), got_idx[0], got_val[0]);
        end
        checks++;
        if (busy !== 1'b0 || n_cmd != 0 || n_fe != 0) begin
            errors++;
            $display("FAIL single_flags: busy=%b cmd=%0d fe=%0d required 0 0 0", busy, n_cmd, n_fe);
        end
        checks++;
        if ((wr_time - 5 - last_start) / 10 < 98 || (wr_time - 5 - last_start) / 10 > 99) begin
            errors++;
            $display("FAIL single_latency: got %0d clocks required 98..99", (wr_time - 5 - last_start) / 10);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        stim = '{8'hA5, 8'h07, 8'hFF, 8'hA5, 8'h00, 8'h00};
        model_stim();
        send_stim();
        repeat (60) @(negedge clk);
        compare_model("b2b");
        checks++;
        if (wr_index !== 3'd0 || wr_value !== 8'h00) begin
            errors++;
            $display("FAIL b2b_hold: got (%0d,%h) required (0,00)", wr_index, wr_value);
        end
    endtask

    task automatic test_bad_index();
        clear_mon();
        send_byte(8'h12);
        send_byte(8'hA5);
        send_byte(8'h09);
        repeat (3) @(negedge clk);
        checks++;
        if (n_cmd != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badidx_cmd: cmd=%0d busy=%b required 1 0", n_cmd, busy);
        end
        send_byte(8'h55);
        repeat (5) @(negedge clk);
        checks++;
        if (got_idx.size() != 0 || n_cmd != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL badidx_after: writes=%0d cmd=%0d busy=%b required 0 1 0", got_idx.size(), n_cmd, busy);
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_byte(8'hA5);
        repeat (380) @(negedge clk);
        checks++;
        if (n_cmd != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: cmd=%0d busy=%b required 0 1", n_cmd, busy);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (n_cmd != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: cmd=%0d busy=%b required 1 0", n_cmd, busy);
        end
        send_byte(8'h02);
        send_byte(8'h10);
        repeat (5) @(negedge clk);
        checks++;
        if (got_idx.size() != 0 || n_cmd != 1) begin
            errors++;
            $display("FAIL timeout_orphan: writes=%0d cmd=%0d required 0 1", got_idx.size(), n_cmd);
        end
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        repeat (5) @(negedge clk);
        checks++;
        if (got_idx.size() != 1 || got_idx[0] !== 3'd2 || got_val[0] !== 8'h10) begin
            errors++;
            $display("FAIL timeout_recover: writes=%0d first (%0d,%h) required 1 (2,10)", got_idx.size(), got_idx[0], got_val[0]);
        end
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_byte(8'hA5, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (n_fe != 1 || busy !== 1'b0 || n_cmd != 0) begin
            errors++;
            $display("FAIL ferr_hdr: fe=%0d busy=%b cmd=%0d required 1 0 0", n_fe, busy, n_cmd);
        end
        send_byte(8'hA5);
        send_byte(8'h03, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (n_fe != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ferr_idx: fe=%0d busy=%b required 2 0", n_fe, busy);
        end
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (n_fe != 2 || n_cmd != 0 || got_idx.size() != 0) begin
            errors++;
            $display("FAIL glitch: fe=%0d cmd=%0d writes=%0d required 2 0 0", n_fe, n_cmd, got_idx.size());
        end
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h42);
        repeat (5) @(negedge clk);
        checks++;
        if (got_idx.size() != 1 || got_idx[0] !== 3'd1 || got_val[0] !== 8'h42) begin
            errors++;
            $display("FAIL ferr_recover: writes=%0d first (%0d,%h) required 1 (1,42)", got_idx.size(), got_idx[0], got_val[0]);
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        send_byte(8'hA5);
        send_byte(8'h04);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (25) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({wr_en, wr_index, wr_value, frame_err, cmd_err, busy} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b required all zero", {wr_en, wr_index, wr_value, frame_err, cmd_err, busy});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (got_idx.size() != 0 || n_cmd != 0 || n_fe != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: writes=%0d cmd=%0d fe=%0d required 0 0 0", got_idx.size(), n_cmd, n_fe);
        end
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h77);
        repeat (5) @(negedge clk);
        checks++;
        if (got_idx.size() != 1 || got_idx[0] !== 3'd4 || got_val[0] !== 8'h77) begin
            errors++;
            $display("FAIL reset_mid_recover: writes=%0d first (%0d,%h) required 1 (4,77)", got_idx.size(), got_idx[0], got_val[0]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            clear_mon();
            stim.delete();
            for (int f = 0; f < 6 + r; f++) begin
                case ($urandom_range(0, 3))
                    0, 1: begin
                        stim.push_back(8'hA5);
                        stim.push_back(8'($urandom_range(0, 7)));
                        stim.push_back(8'($urandom_range(0, 255)));
                    end
                    2: begin
                        stim.push_back(8'hA5);
                        stim.push_back(8'($urandom_range(8, 255)));
                    end
                    default: stim.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            model_stim();
            send_stim();
            repeat (500) @(negedge clk);
            compare_model("random");
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_index();
        test_timeout();
        test_frame_err();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
